// File: rtl/mult_seq_nxn.sv
// Sequential WIDTH x WIDTH shift-add multiplier with start/done handshake.
// Signed operands are multiplied as magnitudes and the sign is applied at completion.
module mult_seq_nxn #(
   parameter int WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 is_signed,
   input  logic [WIDTH-1:0]     A,
   input  logic [WIDTH-1:0]     B,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   Product
);

   localparam int PW = 2 * WIDTH;
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [WIDTH-1:0]  mcand_q, mcand_d;
   logic [WIDTH-1:0]  mplier_q, mplier_d;
   logic              neg_q, neg_d;
   logic [PW:0]       acc_q, acc_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [PW-1:0]     prod_q, prod_d;
   logic              busy_q, done_q;
   logic [WIDTH:0]    sum_s;

   // Two's-complement magnitude; -2^(WIDTH-1) maps to 2^(WIDTH-1), which still fits unsigned
   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
      logic [WIDTH-1:0] m;
      if (sgn && v[WIDTH-1]) begin
         m = ~v + WIDTH'(1);
      end else begin
         m = v;
      end
      return m;
   endfunction

   // Next-state and datapath: capture on acceptance, one shift-add step per RUN edge
   always_comb begin
      state_d  = state_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      neg_d    = neg_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      prod_d   = prod_q;
      sum_s    = acc_q[PW:WIDTH] + (mplier_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               mcand_d  = magnitude(A, is_signed);
               mplier_d = magnitude(B, is_signed);
               neg_d    = is_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
               acc_d    = '0;
               cnt_d    = CW'(WIDTH);
               state_d  = S_RUN;
            end else begin
               state_d  = S_IDLE;
            end
         end
         S_RUN: begin
            // The carry out of the upper-half add lands in the top bit before shifting
            acc_d    = {sum_s, acc_q[WIDTH-1:0]} >> 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               prod_d  = neg_q ? (~acc_d[PW-1:0] + PW'(1)) : acc_d[PW-1:0];
               state_d = S_DONE;
            end else begin
               state_d = S_RUN;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State, datapath and registered handshake outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         mcand_q  <= '0;
         mplier_q <= '0;
         neg_q    <= 1'b0;
         acc_q    <= '0;
         cnt_q    <= '0;
         prod_q   <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         neg_q    <= neg_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         prod_q   <= prod_d;
         busy_q   <= (state_d == S_RUN);
         done_q   <= (state_d == S_DONE);
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign Product = prod_q;

endmodule

// File: tb/tb_mult_seq_nxn.sv
// Self-checking bench for mult_seq_nxn at WIDTH 4, 8 and 16, directed cases plus
// randomized operations checked against an integer-arithmetic reference.
module tb_mult_seq_nxn;

   logic        clk;
   logic        rst;
   logic [2:0]  start_v;
   logic [2:0]  sgn_v;
   logic [15:0] a_s [3];
   logic [15:0] b_s [3];
   logic [2:0]  busy_v;
   logic [2:0]  done_v;
   logic [7:0]  p4;
   logic [15:0] p8;
   logic [31:0] p16;

   int n_checks = 0;
   int n_fail   = 0;

   mult_seq_nxn #(.WIDTH(4)) dut4 (
      .clk(clk), .rst(rst), .start(start_v[0]), .is_signed(sgn_v[0]),
      .A(a_s[0][3:0]), .B(b_s[0][3:0]), .busy(busy_v[0]), .done(done_v[0]), .Product(p4)
   );
   mult_seq_nxn #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .start(start_v[1]), .is_signed(sgn_v[1]),
      .A(a_s[1][7:0]), .B(b_s[1][7:0]), .busy(busy_v[1]), .done(done_v[1]), .Product(p8)
   );
   mult_seq_nxn #(.WIDTH(16)) dut16 (
      .clk(clk), .rst(rst), .start(start_v[2]), .is_signed(sgn_v[2]),
      .A(a_s[2]), .B(b_s[2]), .busy(busy_v[2]), .done(done_v[2]), .Product(p16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input longint got, input longint exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic longint prod(input int d);
      case (d)
         0:       return longint'(p4);
         1:       return longint'(p8);
         default: return longint'(p16);
      endcase
   endfunction

   // Reference: interpret operands as integers of width w, multiply, keep 2w bits
   function automatic longint ref_prod(input int w, input logic sgn, input logic [15:0] a,
                                       input logic [15:0] b);
      longint mask = (longint'(1) << w) - 1;
      longint va = longint'(a) & mask;
      longint vb = longint'(b) & mask;
      if (sgn && a[w-1]) va = va - (longint'(1) << w);
      if (sgn && b[w-1]) vb = vb - (longint'(1) << w);
      return (va * vb) & ((longint'(1) << (2 * w)) - 1);
   endfunction

   task automatic run_op(input int d, input logic sgn, input logic [15:0] a,
                         input logic [15:0] b, input longint exp);
      int w = 4 << d;
      int lat = 0;
      longint held;
      @(negedge clk);
      a_s[d] = a;
      b_s[d] = b;
      sgn_v[d] = sgn;
      start_v[d] = 1'b1;
      @(posedge clk);
      #1;
      start_v[d] = 1'b0;
      a_s[d] = 16'($urandom);
      b_s[d] = 16'($urandom);
      sgn_v[d] = 1'($urandom);
      check("busy_after_accept", longint'(busy_v[d]), 1);
      while (!done_v[d] && lat < 4 * w + 8) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check("latency", lat, w);
      check("product", prod(d), exp);
      check("busy_low_at_done", longint'(busy_v[d]), 0);
      held = prod(d);
      @(posedge clk);
      #1;
      check("done_single_pulse", longint'(done_v[d]), 0);
      check("product_hold", prod(d), held);
   endtask

   initial begin
      longint exp_q[$];
      int cyc;
      int last_done;
      int ndone;
      logic seen_done;

      rst = 1'b1;
      start_v = 3'b000;
      sgn_v = 3'b000;
      for (int i = 0; i < 3; i++) begin
         a_s[i] = 16'd0;
         b_s[i] = 16'd0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
         check("reset_busy", longint'(busy_v[d]), 0);
         check("reset_done", longint'(done_v[d]), 0);
         check("reset_product", prod(d), 0);
      end
      @(negedge clk);
      rst = 1'b0;

      run_op(0, 1'b0, 16'd15, 16'd15, 64'hE1);
      for (int a = 1; a < 16; a++) begin
         run_op(0, 1'b0, 16'(a), 16'd8, longint'(a * 8));
         run_op(0, 1'b0, 16'(a), 16'd15, longint'(a * 15));
      end
      run_op(0, 1'b1, 16'h8, 16'h8, 64'h40);
      run_op(0, 1'b1, 16'h7, 16'h8, 64'hC8);
      run_op(0, 1'b1, 16'hF, 16'h1, 64'hFF);
      run_op(0, 1'b1, 16'h0, 16'hB, 64'h00);

      // start held high: one acceptance whenever busy is low
      cyc = 0;
      last_done = -1;
      ndone = 0;
      @(negedge clk);
      start_v[0] = 1'b1;
      repeat (20) begin
         a_s[0] = 16'($urandom);
         b_s[0] = 16'($urandom);
         sgn_v[0] = 1'($urandom);
         if (!busy_v[0]) exp_q.push_back(ref_prod(4, sgn_v[0], a_s[0], b_s[0]));
         @(posedge clk);
         #1;
         cyc++;
         check("b2b_no_overlap", longint'(busy_v[0] & done_v[0]), 0);
         if (done_v[0]) begin
            if (exp_q.size() > 0) check("b2b_product", prod(0), exp_q.pop_front());
            else check("b2b_unexpected_done", 1, 0);
            if (last_done >= 0) check("b2b_gap", cyc - last_done, 5);
            last_done = cyc;
            ndone++;
         end
         @(negedge clk);
      end
      start_v[0] = 1'b0;
      check("b2b_count", ndone, 4);
      check("b2b_leftover", exp_q.size(), 0);
      repeat (2) @(posedge clk);

      // reset on edge 2 of a running operation
      @(negedge clk);
      a_s[0] = 16'd13;
      b_s[0] = 16'd11;
      sgn_v[0] = 1'b0;
      start_v[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start_v[0] = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("abort_busy", longint'(busy_v[0]), 0);
      check("abort_done", longint'(done_v[0]), 0);
      check("abort_product", prod(0), 0);
      @(negedge clk);
      rst = 1'b0;
      seen_done = 1'b0;
      repeat (6) begin
         @(posedge clk);
         #1;
         seen_done = seen_done | done_v[0];
      end
      check("abort_no_done", longint'(seen_done), 0);
      run_op(0, 1'b0, 16'd13, 16'd11, 64'd143);

      // reset wins over start on the same edge
      @(negedge clk);
      rst = 1'b1;
      start_v[0] = 1'b1;
      @(posedge clk);
      #1;
      check("reset_over_start", longint'(busy_v[0]), 0);
      @(negedge clk);
      rst = 1'b0;
      start_v[0] = 1'b0;

      run_op(1, 1'b0, 16'hFF, 16'hFF, 64'hFE01);
      run_op(1, 1'b1, 16'h80, 16'h80, 64'h4000);
      run_op(1, 1'b1, 16'h7F, 16'h80, 64'hC080);
      run_op(2, 1'b1, 16'h8000, 16'h8000, 64'h4000_0000);

      for (int d = 0; d < 3; d++) begin
         for (int n = 0; n < 1000; n++) begin
            logic        s;
            logic [15:0] ra;
            logic [15:0] rb;
            s  = 1'($urandom);
            ra = 16'($urandom);
            rb = 16'($urandom);
            run_op(d, s, ra, rb, ref_prod(4 << d, s, ra, rb));
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mult_seq_nxn.md
# mult_seq_nxn

Parametrised sequential N×N multiplier with a start/done handshake and unsigned or two's-complement mode. It generalises the fixed 4×4 combinational Wallace-tree multiplier to any operand width. It trades area for latency: one partial product is accumulated per clock. It sits beside the Wallace multiplier in the arithmetic library and uses the same `A`/`B`/`Product` port naming, so the same testbench sweeps can drive it.

## Interface
- `WIDTH`, default 4: operand width in bits; legal range 2..32.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `start` input 1: request to multiply; sampled only when `busy`=0.
- `is_signed` input 1: 1 = operands and result are two's complement; 0 = unsigned. Captured with the operands.
- `A` input WIDTH: multiplicand; captured on the accepting edge.
- `B` input WIDTH: multiplier; captured on the accepting edge.
- `busy` output 1: high while an operation is in progress.
- `done` output 1: single-cycle pulse when `Product` is valid.
- `Product` output 2*WIDTH: result; holds its value until the next completion or reset.

## Operation
- States:
  - IDLE: reset state.
  - RUN: shift-add in progress.
  - DONE: one cycle, `done`=1.
- IDLE/DONE → RUN when `start`=1. That edge is the accepting edge.
  - Capture `A`, `B`, `is_signed`.
  - Clear the accumulator.
  - Load the iteration counter with `WIDTH`.
- Signed mode, at capture:
  - Store |A| and |B| as WIDTH-bit unsigned magnitudes.
  - Store `neg` = A[MSB] XOR B[MSB].
  - |−2^(WIDTH−1)| = 2^(WIDTH−1) fits in WIDTH unsigned bits; no overflow case exists.
- Unsigned mode: magnitudes = raw operands; `neg`=0.
- RUN, one iteration per edge:
  - If the multiplier LSB is 1, add the multiplicand magnitude to the accumulator upper half.
  - Shift the {carry, accumulator} right by one.
  - Shift the multiplier right by one.
  - Decrement the counter.
  - The accumulator is 2*WIDTH+1 bits wide internally (carry bit).
- On the edge where the counter reaches 0:
  - Write `Product` ← `neg` ? −acc : acc, truncated to 2*WIDTH bits.
  - State → DONE.
- The result is always exact; 2*WIDTH bits hold every signed and unsigned product.
  - Signed worst case, WIDTH=4: (−8)×(−8) = +64 = 0x40.
- DONE → IDLE when `start`=0. DONE → RUN when `start`=1 (back-to-back; new operands captured that edge).
- `start` while `busy`=1 is ignored: operands are not re-captured and the operation in flight is unaffected.
- `A`, `B` and `is_signed` may change freely after the accepting edge.

## Timing
- Reset (rst=1 at an edge):
  - State = IDLE, `busy`=0, `done`=0, `Product`=0.
  - Counter and accumulator cleared.
  - Reset wins over `start` on the same edge.
- Reset mid-RUN aborts the operation. No `done` pulse follows; `Product` reads 0.
- Accepting edge = edge 0:
  - `busy`=1 from edge 0.
  - Iterations on edges 1..WIDTH.
  - At edge WIDTH: `Product` updated, `busy`=0, `done`=1 for one cycle.
  - Latency: WIDTH cycles from acceptance to `done`.
- Throughput with back-to-back `start`: one result every WIDTH+1 cycles. DONE holds `busy`=0 for exactly one cycle.
- `Product` is registered and changes only on a completion edge or reset. Between completions it is stable.
- `done` and `busy` are never high in the same cycle.

## Test plan
- Reset, then WIDTH=4 unsigned `A`=15, `B`=15, `start` pulse → `done` exactly 4 cycles after acceptance, `Product`=0xE1 (225). Then sweep A=1..15 × B∈{8,15} → each `Product` = A×B.
- WIDTH=4 signed:
  - (−8)×(−8) → 0x40.
  - 7×(−8) → 0xC8 (−56).
  - (−1)×1 → 0xFF.
  - 0×(−5) → 0x00.
- `start` held high continuously with new operands each cycle → results only every 5 cycles. Operands presented during `busy` are ignored; each result matches the operands present on its accepting edge.
- Assert `rst` on edge 2 of a 4-cycle operation → `busy`=0, no `done` pulse, `Product`=0 on the next cycle. A new start then completes normally.
- WIDTH=8 unsigned 255×255 → `Product`=0xFE01 after 8 cycles. Signed (−128)×(−128) → 0x4000. Signed 127×(−128) → 0xC080.
- Random regression, WIDTH∈{4,8,16}, 1000 operations each with random `is_signed` → every `Product` equals the reference product. `done` is always a single-cycle pulse.
